// File: rtl/mem_stage_responder_if.sv
// Execute-to-memory request bus and MEM/WB writeback bus of the memory stage.
// The master is the execute side; the slave is the memory-stage responder.
interface mem_stage_responder_if;
    logic        MemWriteM;
    logic        MemToRegM;
    logic        RegWriteM;
    logic        PCSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  WA3M;
    logic        StallM;
    logic        MemFaultM;
    logic [31:0] FaultAddr;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [3:0]  WA3W;
    logic        RegWriteW;
    logic        MemToRegW;
    logic        PCSrcW;

    modport master (
        output MemWriteM, MemToRegM, RegWriteM, PCSrcM, ALUResultM, WriteDataM, WA3M,
        input  StallM, MemFaultM, FaultAddr, ReadDataW, ALUOutW, WA3W,
               RegWriteW, MemToRegW, PCSrcW
    );

    modport slave (
        input  MemWriteM, MemToRegM, RegWriteM, PCSrcM, ALUResultM, WriteDataM, WA3M,
        output StallM, MemFaultM, FaultAddr, ReadDataW, ALUOutW, WA3W,
               RegWriteW, MemToRegW, PCSrcW
    );
endinterface

// File: rtl/mem_stage_responder.sv
// Memory stage: word-addressed data RAM with configurable load latency, load stall FSM and MEM/WB register.
// Optional macro MEM_FAULT_STICKY_EN latches the address of the first faulting access into FaultAddr.
module mem_stage_responder #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2
) (
    input logic                  Clk,
    input logic                  reset,
    mem_stage_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT   = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [31:0]   ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
    endfunction

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          load, store, fault, load_ok, store_ok, stall;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   ram [DEPTH_WORDS];

    // Store wins when both requests are raised, so a load only counts without MemWriteM.
    assign load     = bus.MemToRegM & bus.RegWriteM & ~bus.MemWriteM;
    assign store    = bus.MemWriteM;
    assign fault    = (load | store) & addr_fault(bus.ALUResultM);
    assign load_ok  = load & ~fault;
    assign store_ok = store & ~fault;
    assign idx      = bus.ALUResultM[AW+1:2];
    assign rd_word  = ram[idx];

    assign bus.MemFaultM = fault;
    assign bus.StallM    = stall & reset;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (load_ok && (READ_LATENCY > 1)) begin
                    next_state = WAIT;
                    next_cnt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt != '0) next_cnt = cnt - 1'b1;
                else           next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = load_ok && (READ_LATENCY > 1);
            WAIT:    stall = (cnt != '0);
            default: stall = 1'b0;
        endcase
    end

    // Write lands at the edge closing the store cycle; a load in the next cycle reads it.
    always_ff @(posedge Clk) begin
        if (reset && store_ok) ram[idx] <= bus.WriteDataM;
    end

    // MEM/WB boundary: a stalled cycle inserts a bubble and holds the data fields
    always_ff @(posedge Clk) begin
        if (!reset) begin
            bus.ReadDataW <= '0;
            bus.ALUOutW   <= '0;
            bus.WA3W      <= '0;
            bus.RegWriteW <= 1'b0;
            bus.MemToRegW <= 1'b0;
            bus.PCSrcW    <= 1'b0;
        end else if (stall) begin
            bus.RegWriteW <= 1'b0;
            bus.MemToRegW <= 1'b0;
            bus.PCSrcW    <= 1'b0;
        end else begin
            bus.ReadDataW <= load_ok ? rd_word : 32'h0;
            bus.ALUOutW   <= bus.ALUResultM;
            bus.WA3W      <= bus.WA3M;
            bus.RegWriteW <= bus.RegWriteM;
            bus.MemToRegW <= bus.MemToRegM;
            bus.PCSrcW    <= bus.PCSrcM;
        end
    end

`ifdef MEM_FAULT_STICKY_EN
    logic        fault_seen;
    logic [31:0] fault_addr_q;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            fault_seen   <= 1'b0;
            fault_addr_q <= '0;
        end else if (fault && !fault_seen) begin
            fault_seen   <= 1'b1;
            fault_addr_q <= bus.ALUResultM;
        end
    end

    assign bus.FaultAddr = fault_addr_q;
`else
    assign bus.FaultAddr = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed bench for mem_stage_responder: three instances with READ_LATENCY 1, 2 and 4.
// Expectations follow MEM_FAULT_STICKY_EN when it is defined for the build.
module tb_mem_stage_responder;

`ifdef MEM_FAULT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst1, rst2, rst4;
    int   n_vec;
    int   n_err;

    mem_stage_responder_if b1 ();
    mem_stage_responder_if b2 ();
    mem_stage_responder_if b4 ();

    mem_stage_responder #(.DEPTH_WORDS(256), .READ_LATENCY(1)) d1 (.Clk(clk), .reset(rst1), .bus(b1));
    mem_stage_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2)) d2 (.Clk(clk), .reset(rst2), .bus(b2));
    mem_stage_responder #(.DEPTH_WORDS(256), .READ_LATENCY(4)) d4 (.Clk(clk), .reset(rst4), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int d, input logic mw, input logic mtr, input logic rw, input logic pc,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wa);
        case (d)
            1: begin
                b1.MemWriteM = mw; b1.MemToRegM = mtr; b1.RegWriteM = rw; b1.PCSrcM = pc;
                b1.ALUResultM = addr; b1.WriteDataM = wd; b1.WA3M = wa;
            end
            2: begin
                b2.MemWriteM = mw; b2.MemToRegM = mtr; b2.RegWriteM = rw; b2.PCSrcM = pc;
                b2.ALUResultM = addr; b2.WriteDataM = wd; b2.WA3M = wa;
            end
            default: begin
                b4.MemWriteM = mw; b4.MemToRegM = mtr; b4.RegWriteM = rw; b4.PCSrcM = pc;
                b4.ALUResultM = addr; b4.WriteDataM = wd; b4.WA3M = wa;
            end
        endcase
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
        req(1, 0, 0, 0, 0, 0, 0, 0);
        req(2, 0, 0, 0, 0, 0, 0, 0);
        req(4, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_stall",     b2.StallM,    0);
        chk("rst_readdata",  b2.ReadDataW, 0);
        chk("rst_aluout",    b2.ALUOutW,   0);
        chk("rst_wa3",       b2.WA3W,      0);
        chk("rst_regwrite",  b2.RegWriteW, 0);
        chk("rst_memtoreg",  b2.MemToRegW, 0);
        chk("rst_pcsrc",     b2.PCSrcW,    0);
        chk("rst_faultaddr", b1.FaultAddr, 0);
        rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        step();

        // ---- READ_LATENCY=2 ----
        req(2, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0);
        #1;
        chk("l2_store_stall", b2.StallM, 0);
        chk("l2_store_fault", b2.MemFaultM, 0);
        step();
        chk("l2_store_aluout", b2.ALUOutW, 32'h10);

        req(2, 0, 0, 1, 0, 32'h1234, 0, 2);
        step();
        chk("l2_alu_regwrite", b2.RegWriteW, 1);
        chk("l2_alu_aluout",   b2.ALUOutW,   32'h1234);
        chk("l2_alu_readdata", b2.ReadDataW, 0);

        req(2, 0, 1, 1, 0, 32'h10, 0, 5);
        #1;
        chk("l2_load_stall", b2.StallM, 1);
        step();
        chk("l2_bubble_regwrite", b2.RegWriteW, 0);
        chk("l2_bubble_hold",     b2.ALUOutW,   32'h1234);
        chk("l2_wait_stall",      b2.StallM,    0);
        step();
        chk("l2_load_data",     b2.ReadDataW, 32'hDEADBEEF);
        chk("l2_load_wa3",      b2.WA3W,      5);
        chk("l2_load_regwrite", b2.RegWriteW, 1);
        chk("l2_load_memtoreg", b2.MemToRegW, 1);

        req(2, 0, 1, 1, 0, 32'h400, 0, 6);
        #1;
        chk("l2_oor_fault", b2.MemFaultM, 1);
        chk("l2_oor_stall", b2.StallM,    0);
        step();
        chk("l2_oor_data",     b2.ReadDataW, 0);
        chk("l2_oor_regwrite", b2.RegWriteW, 1);
        chk("l2_oor_wa3",      b2.WA3W,      6);
        chk("l2_oor_faddr",    b2.FaultAddr, STICKY ? 32'h400 : 32'h0);

        req(2, 1, 0, 0, 0, 32'h12, 32'h11111111, 0);
        #1;
        chk("l2_mis_fault", b2.MemFaultM, 1);
        chk("l2_mis_stall", b2.StallM,    0);
        step();
        chk("l2_mis_faddr", b2.FaultAddr, STICKY ? 32'h400 : 32'h0);

        req(2, 0, 1, 1, 0, 32'h10, 0, 7);
        #1;
        chk("l2_reload_stall", b2.StallM, 1);
        step();
        step();
        chk("l2_reload_data", b2.ReadDataW, 32'hDEADBEEF);
        req(2, 0, 0, 0, 0, 0, 0, 0);

        // ---- READ_LATENCY=1 ----
        for (int k = 0; k < 3; k++) begin
            req(1, 1, 0, 0, 0, 32'(4 * k), 32'(k + 1), 0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            req(1, 0, 1, 1, 0, 32'(4 * k), 0, 4'(k + 1));
            #1;
            chk("l1_b2b_stall", b1.StallM, 0);
            step();
            chk("l1_b2b_data", b1.ReadDataW, 32'(k + 1));
            chk("l1_b2b_wa3",  b1.WA3W,      32'(k + 1));
        end

        req(1, 0, 1, 1, 0, 32'h13, 0, 9);
        #1;
        chk("l1_f13_fault", b1.MemFaultM, 1);
        step();
        chk("l1_f13_faddr", b1.FaultAddr, STICKY ? 32'h13 : 32'h0);
        chk("l1_f13_data",  b1.ReadDataW, 0);
        req(1, 1, 0, 0, 0, 32'h500, 32'hCAFE, 0);
        #1;
        chk("l1_f500_fault", b1.MemFaultM, 1);
        step();
        chk("l1_f500_faddr", b1.FaultAddr, STICKY ? 32'h13 : 32'h0);
        req(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("l1_nop_fault", b1.MemFaultM, 0);
        step();
        chk("l1_hold_faddr", b1.FaultAddr, STICKY ? 32'h13 : 32'h0);
        rst1 = 1'b0;
        step();
        chk("l1_rst_faddr", b1.FaultAddr, 0);
        rst1 = 1'b1;

        // ---- READ_LATENCY=4 ----
        req(4, 1, 0, 0, 0, 32'h20, 32'h77, 0);
        step();
        req(4, 0, 0, 1, 1, 32'hABCD, 0, 3);
        step();
        chk("l4_alu_pcsrc",  b4.PCSrcW,  1);
        chk("l4_alu_aluout", b4.ALUOutW, 32'hABCD);
        req(4, 0, 1, 1, 0, 32'h20, 0, 7);
        #1;
        chk("l4_stall1", b4.StallM, 1);
        step();
        chk("l4_stall2", b4.StallM, 1);
        rst4 = 1'b0;
        step();
        chk("l4_abort_stall",    b4.StallM,    0);
        chk("l4_abort_regwrite", b4.RegWriteW, 0);
        chk("l4_abort_pcsrc",    b4.PCSrcW,    0);
        chk("l4_abort_memtoreg", b4.MemToRegW, 0);
        chk("l4_abort_aluout",   b4.ALUOutW,   0);
        chk("l4_abort_wa3",      b4.WA3W,      0);
        chk("l4_abort_data",     b4.ReadDataW, 0);
        rst4 = 1'b1;
        #1;
        chk("l4_idle_stall", b4.StallM, 1);
        n = 0;
        while (b4.StallM && n < 10) begin
            step();
            n++;
        end
        chk("l4_stall_cycles", 32'(n), 3);
        step();
        chk("l4_load_data", b4.ReadDataW, 32'h77);
        chk("l4_load_wa3",  b4.WA3W,      7);
        req(4, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_responder.md
Name: mem_stage_responder

Overview:
- Memory-stage responder for the pipelined ARM core. It consumes the execute-stage memory request: address (ALU result), write data, MemWrite, MemToReg, RegWrite, WA3 and PCSrc.
- It serves the request from an internal word-addressed data RAM with configurable read latency. It stalls the pipeline while a load is outstanding.
- It owns the MEM/WB pipeline register that feeds writeback.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM (power of two, >=4).
- READ_LATENCY, 2, cycles from load issue to data captured in MEM/WB (>=1).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- MemWriteM  in  1  store request.
- MemToRegM  in  1  load select.
- RegWriteM  in  1  condition-passed register write.
- PCSrcM  in  1  condition-passed PC write.
- ALUResultM  in  32  byte address, or ALU result for non-memory ops.
- WriteDataM  in  32  store data.
- WA3M  in  4  destination register.
- StallM  out  1  combinational; freezes upstream stages and holds all inputs stable.
- ReadDataW  out  32  loaded word.
- ALUOutW  out  32  registered ALUResultM.
- WA3W  out  4  registered destination.
- RegWriteW  out  1  registered write enable.
- MemToRegW  out  1  registered load select.
- PCSrcW  out  1  registered PC select.
- MemFaultM  out  1  combinational; current access is misaligned or out of range.
- FaultAddr  out  32  see Optional Feature.

Behaviour:
- Reset: while reset==0 at a clock edge:
  - state=IDLE, latency counter=0.
  - All W outputs and FaultAddr = 0.
  - StallM=0 for the cycle after reset.
  - RAM contents are not cleared.
- Request decode:
  - load = MemToRegM & RegWriteM.
  - store = MemWriteM.
  - load and store asserted together is illegal; store takes priority and load is ignored.
- Address checks:
  - word index = ALUResultM[log2(DEPTH_WORDS)+1:2].
  - Fault when (load|store) and either ALUResultM[1:0]!=0 or ALUResultM >= 4*DEPTH_WORDS.
  - Faulted store: no RAM write.
  - Faulted load: ReadDataW=0, RegWriteW still registered as 1, no stall (treated as READ_LATENCY=1).
- Store: written to RAM at the edge ending the request cycle. No stall. MEM/WB captures normally.
- Non-memory op: MEM/WB captures every non-stalled cycle; ReadDataW=0.
- FSM IDLE/WAIT:
  - IDLE, valid load, READ_LATENCY==1: StallM=0; MEM/WB captures RAM word this edge.
  - IDLE, valid load, READ_LATENCY>1: StallM=1; next state WAIT, counter=READ_LATENCY-2.
  - WAIT, counter!=0: StallM=1; counter decrements.
  - WAIT, counter==0: StallM=0; MEM/WB captures RAM word; next state IDLE.
  - Total stall = READ_LATENCY-1 cycles per load.
- During any StallM=1 cycle, MEM/WB loads a bubble: RegWriteW=0, PCSrcW=0, MemToRegW=0; data fields hold.
- Back-to-back loads: the second load is seen in IDLE on the cycle after capture. No lost or duplicated request.
- Load after store to the same word in the previous cycle returns the new data (write-first RAM ordering at edge).
- Reset asserted in WAIT: abort to IDLE, bubble in MEM/WB, no data returned.

Optional Feature:
- Macro MEM_FAULT_STICKY_EN.
- Defined:
  - On the first fault after reset, FaultAddr latches ALUResultM.
  - Later faults do not overwrite it; only reset clears it.
  - MemFaultM remains per-cycle.
- Undefined: FaultAddr is tied to 0.

Test Plan:
- READ_LATENCY=2:
  - Store 0xDEADBEEF to 0x10, then load 0x10 to WA3=5.
  - Required: StallM high exactly 1 cycle, with a bubble (RegWriteW=0) in that cycle.
  - Required next edge: ReadDataW=0xDEADBEEF, WA3W=5, RegWriteW=1.
- READ_LATENCY=1: three back-to-back loads of 0x0/0x4/0x8 holding 1/2/3 -> StallM never high; ReadDataW=1,2,3 on consecutive cycles.
- Misaligned store to 0x12 -> MemFaultM=1, RAM word 0x10 unchanged.
- Load from 0x400 with DEPTH_WORDS=256 -> MemFaultM=1, ReadDataW=0, no stall.
- READ_LATENCY=4: load issued, reset driven low in 2nd stall cycle -> next cycle StallM=0, all W outputs 0, state IDLE.
- MEM_FAULT_STICKY_EN defined: faults at 0x13 then 0x500 -> FaultAddr=0x00000013 held until reset.
- MEM_FAULT_STICKY_EN undefined: same faults -> FaultAddr stays 0.
